// File: rtl/speicher_antworter_pkg.sv
// Shared encodings for the memory responder: FSM states and request kinds.
package speicher_antworter_pkg;
  typedef enum logic [1:0] {
    LEERLAUF  = 2'd0,
    WARTEN    = 2'd1,
    ANTWORT   = 2'd2,
    ABSCHLUSS = 2'd3
  } zustand_t;

  typedef enum logic [1:0] {
    INSTR     = 2'd0,
    LADEN     = 2'd1,
    SPEICHERN = 2'd2
  } art_t;

  localparam int WORT_BREITE = 32;
endpackage

// File: rtl/speicher_block.sv
// Synchronous single-port word RAM with registered read data (read-first).
module speicher_block
  import speicher_antworter_pkg::*;
#(
  parameter int ADRESS_BREITE = 10
) (
  input  logic                     Clock,
  input  logic [ADRESS_BREITE-1:0] i_adresse,
  input  logic                     i_schreiben,
  input  logic [WORT_BREITE-1:0]   i_wdaten,
  output logic [WORT_BREITE-1:0]   o_rdaten
);
  logic [WORT_BREITE-1:0] r_mem [2**ADRESS_BREITE];

  always_ff @(posedge Clock) begin
    if (i_schreiben) r_mem[i_adresse] <= i_wdaten;
    o_rdaten <= r_mem[i_adresse];
  end
endmodule

// File: rtl/speicher_antworter.sv
// Memory responder: arbitrates fetch/load/store level requests onto one RAM,
// inserts WARTEZYKLEN wait cycles and answers with one-cycle acknowledges.
module speicher_antworter
  import speicher_antworter_pkg::*;
#(
  parameter int ADRESS_BREITE = 10,
  parameter int WARTEZYKLEN   = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] InstruktionAdresse,
  input  logic        LeseInstruktion,
  output logic [31:0] Instruktion,
  output logic        InstruktionGeladen,
  input  logic [31:0] DatenAdresse,
  input  logic [31:0] DatenRaus,
  input  logic        LeseDaten,
  input  logic        SchreibeDaten,
  output logic [31:0] DatenRein,
  output logic        DatenGeladen,
  output logic        DatenGespeichert
);
  zustand_t                 r_zustand, w_zustand_n;
  art_t                     r_art, w_art;
  logic [3:0]               r_zaehler;
  logic [ADRESS_BREITE-1:0] r_adresse, w_adr_ein, w_ram_adr;
  logic [31:0]              r_daten, w_rdaten;
  logic                     w_anfrage, w_fertig, w_schreiben, w_anfrage_aktiv;
  logic                     w_unused_bits;

  assign w_unused_bits = ^{InstruktionAdresse[31:ADRESS_BREITE], DatenAdresse[31:ADRESS_BREITE]};

  always_comb begin
    w_anfrage = SchreibeDaten | LeseDaten | LeseInstruktion;
    w_art     = INSTR;
    if (SchreibeDaten)  w_art = SPEICHERN;
    else if (LeseDaten) w_art = LADEN;
    w_adr_ein = (w_art == INSTR) ? InstruktionAdresse[ADRESS_BREITE-1:0]
                                 : DatenAdresse[ADRESS_BREITE-1:0];
    // In LEERLAUF the RAM already reads the incoming address so the word is
    // ready in time even with zero wait cycles.
    w_ram_adr   = (r_zustand == LEERLAUF) ? w_adr_ein : r_adresse;
    w_fertig    = (r_zustand == WARTEN) && (r_zaehler == 4'd0);
    w_schreiben = w_fertig && (r_art == SPEICHERN);
    case (r_art)
      SPEICHERN: w_anfrage_aktiv = SchreibeDaten;
      LADEN:     w_anfrage_aktiv = LeseDaten;
      default:   w_anfrage_aktiv = LeseInstruktion;
    endcase
  end

  always_comb begin
    w_zustand_n = r_zustand;
    case (r_zustand)
      LEERLAUF:  if (w_anfrage) w_zustand_n = WARTEN;
      WARTEN:    if (r_zaehler == 4'd0) w_zustand_n = ANTWORT;
      ANTWORT:   w_zustand_n = ABSCHLUSS;
      ABSCHLUSS: if (!w_anfrage_aktiv) w_zustand_n = LEERLAUF;
      default:   w_zustand_n = LEERLAUF;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_zustand <= LEERLAUF;
    else       r_zustand <= w_zustand_n;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_art              <= INSTR;
      r_adresse          <= '0;
      r_daten            <= '0;
      r_zaehler          <= 4'd0;
      Instruktion        <= '0;
      DatenRein          <= '0;
      InstruktionGeladen <= 1'b0;
      DatenGeladen       <= 1'b0;
      DatenGespeichert   <= 1'b0;
    end else begin
      InstruktionGeladen <= 1'b0;
      DatenGeladen       <= 1'b0;
      DatenGespeichert   <= 1'b0;
      if (r_zustand == LEERLAUF && w_anfrage) begin
        r_art     <= w_art;
        r_adresse <= w_adr_ein;
        r_daten   <= DatenRaus;
        r_zaehler <= 4'(WARTEZYKLEN);
      end else if (r_zustand == WARTEN && r_zaehler != 4'd0) begin
        r_zaehler <= r_zaehler - 4'd1;
      end
      if (w_fertig) begin
        case (r_art)
          SPEICHERN: DatenGespeichert <= 1'b1;
          LADEN: begin
            DatenRein    <= w_rdaten;
            DatenGeladen <= 1'b1;
          end
          default: begin
            Instruktion        <= w_rdaten;
            InstruktionGeladen <= 1'b1;
          end
        endcase
      end
    end
  end

  speicher_block #(.ADRESS_BREITE(ADRESS_BREITE)) u_ram (
    .Clock       (Clock),
    .i_adresse   (w_ram_adr),
    .i_schreiben (w_schreiben),
    .i_wdaten    (r_daten),
    .o_rdaten    (w_rdaten)
  );
endmodule

// File: tb/tb_speicher_antworter.sv
// Two responders (0 and 2 wait cycles) share one stimulus stream and are
// checked against a word-array model and fixed vectors.
module tb_speicher_antworter;
  localparam int AB = 10;
  localparam int DEPTH = 1 << AB;
  localparam int WV[2] = '{0, 2};

  logic        Clock = 1'b0, Reset = 1'b1;
  logic [31:0] ia = '0, da = '0, dr = '0;
  logic        li = 1'b0, ld = 1'b0, sd = 1'b0;
  logic [31:0] instr[2], dout[2];
  logic        ai[2], al[2], as_[2];

  int          n_chk = 0, n_fail = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] last_i = '0, last_d = '0;
  logic [31:0] got[2];

  always #5 Clock = ~Clock;

  speicher_antworter #(.ADRESS_BREITE(AB), .WARTEZYKLEN(0)) dut0 (
    .Clock(Clock), .Reset(Reset),
    .InstruktionAdresse(ia), .LeseInstruktion(li), .Instruktion(instr[0]), .InstruktionGeladen(ai[0]),
    .DatenAdresse(da), .DatenRaus(dr), .LeseDaten(ld), .SchreibeDaten(sd),
    .DatenRein(dout[0]), .DatenGeladen(al[0]), .DatenGespeichert(as_[0]));

  speicher_antworter #(.ADRESS_BREITE(AB), .WARTEZYKLEN(2)) dut1 (
    .Clock(Clock), .Reset(Reset),
    .InstruktionAdresse(ia), .LeseInstruktion(li), .Instruktion(instr[1]), .InstruktionGeladen(ai[1]),
    .DatenAdresse(da), .DatenRaus(dr), .LeseDaten(ld), .SchreibeDaten(sd),
    .DatenRein(dout[1]), .DatenGeladen(al[1]), .DatenGespeichert(as_[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int d, input int kind);
    case (kind)
      0: return ai[d];
      1: return al[d];
      default: return as_[d];
    endcase
  endfunction

  // kind: 0 fetch, 1 load, 2 store. Request is held 12 edges, then dropped.
  task automatic do_op(input int kind, input logic [31:0] adr, input logic [31:0] wd, input bit scramble);
    int first[2], cnt[2], other[2];
    logic [31:0] at_ack[2];
    logic [31:0] exp;
    int m;
    m = int'(adr % DEPTH);
    @(negedge Clock);
    li = (kind == 0); ld = (kind == 1); sd = (kind == 2);
    ia = adr; da = adr; dr = wd;
    if (kind == 2) mem[m] = wd;
    exp = mem[m];
    for (int d = 0; d < 2; d++) begin first[d] = -1; cnt[d] = 0; other[d] = 0; at_ack[d] = '0; end
    for (int t = 0; t < 12; t++) begin
      @(posedge Clock); #1;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 3; k++)
          if (ack_of(d, k)) begin
            if (k == kind) begin
              cnt[d]++;
              if (first[d] < 0) begin
                first[d] = t;
                at_ack[d] = (kind == 0) ? instr[d] : dout[d];
              end
            end else other[d]++;
          end
      end
      if (scramble && t == 0) begin ia = $urandom; da = $urandom; dr = $urandom; end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("latency d%0d k%0d", d, kind), 32'(first[d]), 32'(WV[d] + 1));
      chk($sformatf("pulses d%0d k%0d", d, kind), 32'(cnt[d]), 32'd1);
      chk($sformatf("stray acks d%0d", d), 32'(other[d]), 32'd0);
      if (kind == 0) begin
        chk($sformatf("instr d%0d @%0d", d, m), at_ack[d], exp);
        chk($sformatf("dout hold d%0d", d), dout[d], last_d);
        got[d] = at_ack[d];
      end else if (kind == 1) begin
        chk($sformatf("dout d%0d @%0d", d, m), at_ack[d], exp);
        chk($sformatf("instr hold d%0d", d), instr[d], last_i);
        got[d] = at_ack[d];
      end
    end
    if (kind == 0) last_i = exp;
    if (kind == 1) last_d = exp;
    @(negedge Clock);
    li = 1'b0; ld = 1'b0; sd = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
  endtask

  typedef struct {
    int          kind;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t vt[9];
    int ts[2], tf[2], nf[2], ns[2];
    logic [31:0] ifa[2];

    // reset state
    repeat (2) @(negedge Clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst instr", instr[d], 32'h0);
      chk("rst dout", dout[d], 32'h0);
      chk("rst acks", {29'd0, ai[d], al[d], as_[d]}, 32'h0);
    end
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 32; i++) do_op(2, 32'(i), 32'(i * 3 + 1), 1'b0);

    vt[0] = '{2, 32'h5,   32'hDEADBEEF, 32'h0};
    vt[1] = '{1, 32'h5,   32'h0,        32'hDEADBEEF};
    vt[2] = '{2, 32'h10,  32'h12345678, 32'h0};
    vt[3] = '{0, 32'h10,  32'h0,        32'h12345678};
    vt[4] = '{2, 32'h403, 32'hA5A5A5A5, 32'h0};
    vt[5] = '{1, 32'h3,   32'h0,        32'hA5A5A5A5};
    vt[6] = '{0, 32'hFFFFFC03, 32'h0,   32'hA5A5A5A5};
    vt[7] = '{0, 32'h10,  32'h0,        32'h12345678};
    vt[8] = '{1, 32'h805, 32'h0,        32'hDEADBEEF};
    for (int i = 0; i < 9; i++) begin
      do_op(vt[i].kind, vt[i].adr, vt[i].wd, 1'b1);
      if (vt[i].kind != 2)
        for (int d = 0; d < 2; d++) chk($sformatf("vec%0d d%0d", i, d), got[d], vt[i].exp);
    end

    for (int i = 0; i < 40; i++)
      do_op($urandom_range(0, 2), ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31)),
            $urandom, 1'($urandom_range(0, 1)));

    // simultaneous store + fetch of the same word: store wins, fetch sees new data
    @(negedge Clock);
    ia = 32'h20; da = 32'h20; dr = 32'hCAFEF00D; sd = 1'b1; li = 1'b1;
    mem[32'h20] = 32'hCAFEF00D;
    for (int d = 0; d < 2; d++) begin ts[d] = -1; tf[d] = -1; nf[d] = 0; ns[d] = 0; ifa[d] = '0; end
    for (int t = 0; t < 25; t++) begin
      @(posedge Clock); #1;
      for (int d = 0; d < 2; d++) begin
        if (as_[d]) begin ns[d]++; if (ts[d] < 0) ts[d] = t; end
        if (ai[d]) begin nf[d]++; if (tf[d] < 0) begin tf[d] = t; ifa[d] = instr[d]; end end
      end
      if (t == 8) sd = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("simul store t d%0d", d), 32'(ts[d]), 32'(WV[d] + 1));
      chk($sformatf("simul fetch t d%0d", d), 32'(tf[d]), 32'(WV[d] + 11));
      chk($sformatf("simul counts d%0d", d), 32'(ns[d] * 16 + nf[d]), 32'h11);
      chk($sformatf("simul data d%0d", d), ifa[d], 32'hCAFEF00D);
    end
    last_i = 32'hCAFEF00D;
    @(negedge Clock); li = 1'b0;
    repeat (2) @(negedge Clock);

    // reset in the middle of a store's wait
    do_op(2, 32'h7, 32'h0, 1'b0);
    do_op(1, 32'h5, 32'h0, 1'b0);
    @(negedge Clock);
    da = 32'h7; dr = 32'h1; sd = 1'b1;
    @(negedge Clock);
    Reset = 1'b1; #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("rst mid outs d%0d", d), instr[d] | dout[d] | {29'd0, ai[d], al[d], as_[d]}, 32'h0);
    @(negedge Clock);
    for (int d = 0; d < 2; d++)
      chk($sformatf("rst hold outs d%0d", d), instr[d] | dout[d] | {29'd0, ai[d], al[d], as_[d]}, 32'h0);
    sd = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    ns[0] = 0; ns[1] = 0;
    for (int t = 0; t < 6; t++) begin
      @(posedge Clock); #1;
      for (int d = 0; d < 2; d++) if (as_[d]) ns[d]++;
    end
    chk("no store ack after rst", 32'(ns[0] + ns[1]), 32'd0);
    last_i = '0; last_d = '0;
    do_op(1, 32'h7, 32'h0, 1'b0);
    for (int d = 0; d < 2; d++) chk($sformatf("ram7 kept d%0d", d), got[d], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
